// File: rtl/redmule_x_feeder.sv
// rtl/redmule_x_feeder.sv - X buffer feeder: 2-entry skid FIFO, column mask, per-tile full/rst_w_index handshake
module redmule_x_feeder #(
   parameter  int unsigned DW    = 288,
   parameter  int unsigned BITW  = 16,
   parameter  int unsigned Width = 12,
   localparam int unsigned NE    = DW / BITW,
   localparam int unsigned RW    = $clog2(Width) + 1,
   localparam int unsigned EW    = $clog2(NE) + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          start_i,
   input  logic [RW-1:0] cfg_rows_i,
   input  logic [EW-1:0] cfg_elems_i,
   input  logic [15:0]   cfg_tiles_i,
   input  logic          x_valid_i,
   output logic          x_ready_o,
   input  logic [DW-1:0] x_data_i,
   output logic          load_o,
   output logic [DW-1:0] data_o,
   input  logic          buf_full_i,
   input  logic          refill_req_i,
   output logic          rst_w_index_o,
   output logic          busy_o,
   output logic          done_o
);

   localparam logic [1:0]    IDLE      = 2'd0;
   localparam logic [1:0]    LOAD      = 2'd1;
   localparam logic [1:0]    WAIT_FULL = 2'd2;
   localparam logic [1:0]    DONE      = 2'd3;
   localparam logic [RW-1:0] ROWS_MAX  = RW'(Width);
   localparam logic [EW-1:0] NE_E      = EW'(NE);

   logic [1:0]    r_state;
   logic [RW-1:0] r_rows;
   logic [RW-1:0] r_row_cnt;
   logic [15:0]   r_tiles;
   logic [15:0]   r_tile_cnt;
   logic [NE-1:0] r_keep;
   logic [DW-1:0] r_mem [2];
   logic          r_wptr;
   logic          r_rptr;
   logic [1:0]    r_cnt;

   logic          w_busy;
   logic          w_push;
   logic          w_pop;
   logic          w_ack;
   logic [NE-1:0] w_keep;
   logic [DW-1:0] w_head;
   logic [DW-1:0] w_data;

   assign w_busy    = (r_state == LOAD) || (r_state == WAIT_FULL);
   assign x_ready_o = w_busy && (r_cnt != 2'd2);
   assign w_push    = x_valid_i && x_ready_o;
   assign w_pop     = (r_state == LOAD) && (r_cnt != 2'd0) && (r_row_cnt < r_rows);
   assign w_ack     = (r_state == WAIT_FULL) && buf_full_i && refill_req_i;
   assign w_head    = r_mem[r_rptr];

   // Per-element keep mask, captured once at start so the datapath only sees a register.
   always_comb begin
      w_keep = '0;
      for (int e = 0; e < NE; e++) begin
         w_keep[e] = (cfg_elems_i == '0) || (cfg_elems_i >= NE_E) || (EW'(e) < cfg_elems_i);
      end
   end

   always_comb begin
      w_data = '0;
      if (w_pop) begin
         for (int e = 0; e < NE; e++) begin
            if (r_keep[e]) w_data[e*BITW +: BITW] = w_head[e*BITW +: BITW];
         end
      end
   end

   assign load_o        = w_pop;
   assign data_o        = w_data;
   assign rst_w_index_o = w_ack;
   assign busy_o        = w_busy;
   assign done_o        = (r_state == DONE);

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= x_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_rows     <= '0;
         r_row_cnt  <= '0;
         r_tiles    <= '0;
         r_tile_cnt <= '0;
         r_keep     <= '0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_cnt      <= 2'd0;
      end else if (clear_i) begin
         r_state    <= IDLE;
         r_rows     <= '0;
         r_row_cnt  <= '0;
         r_tiles    <= '0;
         r_tile_cnt <= '0;
         r_keep     <= '0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_cnt      <= 2'd0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_rows     <= (cfg_rows_i == '0) ? ROWS_MAX : cfg_rows_i;
                  r_tiles    <= cfg_tiles_i;
                  r_keep     <= w_keep;
                  r_row_cnt  <= '0;
                  r_tile_cnt <= '0;
                  r_state    <= (cfg_tiles_i == 16'd0) ? DONE : LOAD;
               end
            end
            LOAD: begin
               if (w_pop) begin
                  r_row_cnt <= r_row_cnt + 1'b1;
                  if (r_row_cnt + 1'b1 == r_rows) r_state <= WAIT_FULL;
               end
            end
            WAIT_FULL: begin
               if (w_ack) begin
                  r_row_cnt  <= '0;
                  r_tile_cnt <= r_tile_cnt + 16'd1;
                  r_state    <= (r_tile_cnt + 16'd1 == r_tiles) ? DONE : LOAD;
               end
            end
            default: begin
               // Rows left in the FIFO belong to no tile; drop them on the way back to IDLE.
               r_state <= IDLE;
               r_wptr  <= 1'b0;
               r_rptr  <= 1'b0;
               r_cnt   <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_redmule_x_feeder.sv
// tb/tb_redmule_x_feeder.sv - directed self-checking bench for redmule_x_feeder
module tb_redmule_x_feeder;
   localparam int DW = 288;
   localparam int NE = 18;
   localparam int RW = 5;
   localparam int EW = 6;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          clear_i = 1'b0;
   logic          start_i = 1'b0;
   logic [RW-1:0] cfg_rows_i = '0;
   logic [EW-1:0] cfg_elems_i = '0;
   logic [15:0]   cfg_tiles_i = '0;
   logic          x_valid_i = 1'b0;
   logic          x_ready_o;
   logic [DW-1:0] x_data_i = '0;
   logic          load_o;
   logic [DW-1:0] data_o;
   logic          buf_full_i = 1'b0;
   logic          refill_req_i = 1'b0;
   logic          rst_w_index_o;
   logic          busy_o;
   logic          done_o;

   redmule_x_feeder #(.DW(288), .BITW(16), .Width(12)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .cfg_rows_i(cfg_rows_i), .cfg_elems_i(cfg_elems_i), .cfg_tiles_i(cfg_tiles_i),
      .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_data_i(x_data_i),
      .load_o(load_o), .data_o(data_o), .buf_full_i(buf_full_i), .refill_req_i(refill_req_i),
      .rst_w_index_o(rst_w_index_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int n_load = 0;
   int n_ack = 0;
   int n_done = 0;
   logic [DW-1:0] ldq [$];

   always @(negedge clk) begin
      if (rst_ni) begin
         if (load_o) begin
            ldq.push_back(data_o);
            n_load++;
         end
         if (rst_w_index_o) n_ack++;
         if (done_o) n_done++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] row(input int k);
      logic [DW-1:0] r;
      for (int e = 0; e < NE; e++) r[e*16 +: 16] = 16'((k << 5) + e + 1);
      return r;
   endfunction

   task automatic do_start(input int r, input int el, input int t);
      logic exp_busy;
      exp_busy = (t != 0);
      cfg_rows_i = RW'(r);
      cfg_elems_i = EW'(el);
      cfg_tiles_i = 16'(t);
      start_i = 1'b1;
      @(posedge clk); #2;
      start_i = 1'b0;
      #1;
      chkb("busy_at_start", busy_o, exp_busy);
      chkb("ready_at_start", x_ready_o, exp_busy);
   endtask

   task automatic push_row(input logic [DW-1:0] d);
      int ok;
      ok = 0;
      x_valid_i = 1'b1;
      x_data_i = d;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (x_ready_o) begin
            ok = 1;
            @(posedge clk); #2;
            break;
         end
         @(posedge clk); #2;
      end
      x_valid_i = 1'b0;
      chki("push_accept", ok, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #2;
      end
   endtask

   task automatic wait_loads(input int target);
      for (int c = 0; c < 100 && n_load < target; c++) begin
         @(posedge clk); #2;
      end
      chki("loads_reached", n_load, target);
   endtask

   task automatic ack(input logic last);
      buf_full_i = 1'b1;
      refill_req_i = 1'b1;
      #1;
      chkb("rst_w_index", rst_w_index_o, 1'b1);
      @(posedge clk); #2;
      buf_full_i = 1'b0;
      refill_req_i = 1'b0;
      #1;
      chkb("done_after_ack", done_o, last);
      chkb("busy_after_ack", busy_o, !last);
      @(posedge clk); #2;
   endtask

   task automatic check_rows(input int base, input int first, input int n);
      for (int i = 0; i < n; i++) chk($sformatf("row_%0d", first + i), ldq[base + i], row(first + i));
   endtask

   initial begin
      int base, a0, d0, idx, acc;
      logic [DW-1:0] r3c, e5, tmp;

      // reset state
      idle(3);
      #1;
      chkb("rst_ready", x_ready_o, 1'b0);
      chkb("rst_load", load_o, 1'b0);
      chkb("rst_w_index", rst_w_index_o, 1'b0);
      chkb("rst_busy", busy_o, 1'b0);
      chkb("rst_done", done_o, 1'b0);
      chk("rst_data", data_o, '0);
      rst_ni = 1'b1;
      idle(2);

      // full tile of 12 back-to-back rows, one tile
      base = n_load; a0 = n_ack; d0 = n_done;
      do_start(12, 0, 1);
      for (int i = 0; i < 12; i++) push_row(row(i));
      wait_loads(base + 12);
      ack(1'b1);
      chki("t1_loads", n_load - base, 12);
      chki("t1_acks", n_ack - a0, 1);
      chki("t1_done", n_done - d0, 1);
      check_rows(base, 0, 12);
      chkb("t1_done_gone", done_o, 1'b0);

      // element mask: 5 of 18 FP16 lanes kept
      r3c = {18{16'h3C00}};
      e5 = '0;
      e5[79:0] = {5{16'h3C00}};
      base = n_load;
      do_start(1, 5, 1);
      push_row(r3c);
      wait_loads(base + 1);
      ack(1'b1);
      tmp = ldq[base];
      chk("mask_row", tmp, e5);
      chk("mask_upper", tmp >> 80, '0);

      // rows=4, tiles=3 with a 10-cycle refill stall after tile 0
      base = n_load; a0 = n_ack; d0 = n_done;
      do_start(4, 0, 3);
      for (int i = 0; i < 4; i++) push_row(row(100 + i));
      wait_loads(base + 4);
      idx = 4;
      acc = 0;
      buf_full_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         x_valid_i = 1'b1;
         x_data_i = row(100 + idx);
         #1;
         if (x_ready_o) begin
            idx++;
            acc++;
         end
         @(posedge clk); #2;
      end
      x_valid_i = 1'b0;
      chki("stall_accepted", acc, 2);
      chki("stall_no_load", n_load - base, 4);
      chkb("stall_ready_low", x_ready_o, 1'b0);
      chki("stall_no_ack", n_ack - a0, 0);
      ack(1'b0);
      push_row(row(106));
      push_row(row(107));
      wait_loads(base + 8);
      ack(1'b0);
      for (int i = 8; i < 12; i++) push_row(row(100 + i));
      wait_loads(base + 12);
      ack(1'b1);
      chki("t3_loads", n_load - base, 12);
      chki("t3_acks", n_ack - a0, 3);
      chki("t3_done", n_done - d0, 1);
      check_rows(base, 100, 12);

      // rows=7, tiles=2, irregular valid gaps
      base = n_load; a0 = n_ack;
      do_start(7, 0, 2);
      for (int i = 0; i < 9; i++) begin
         push_row(row(200 + i));
         idle(i % 3);
      end
      wait_loads(base + 7);
      idle(3);
      chki("gap_row_cap", n_load - base, 7);
      chkb("gap_fifo_full", x_ready_o, 1'b0);
      ack(1'b0);
      for (int i = 9; i < 14; i++) begin
         push_row(row(200 + i));
         idle((i + 1) % 3);
      end
      wait_loads(base + 14);
      ack(1'b1);
      chki("gap_loads", n_load - base, 14);
      chki("gap_acks", n_ack - a0, 2);
      check_rows(base, 200, 14);

      // soft clear after 3 loads, then a clean restart
      base = n_load; d0 = n_done;
      do_start(12, 0, 1);
      for (int i = 0; i < 3; i++) push_row(row(300 + i));
      wait_loads(base + 3);
      clear_i = 1'b1;
      x_valid_i = 1'b1;
      x_data_i = row(399);
      @(posedge clk); #2;
      clear_i = 1'b0;
      x_valid_i = 1'b0;
      #1;
      chkb("clr_busy", busy_o, 1'b0);
      chkb("clr_ready", x_ready_o, 1'b0);
      chkb("clr_load", load_o, 1'b0);
      chk("clr_data", data_o, '0);
      chkb("clr_done", done_o, 1'b0);
      idle(1);
      base = n_load;
      do_start(2, 0, 1);
      push_row(row(400));
      push_row(row(401));
      wait_loads(base + 2);
      ack(1'b1);
      chki("clr_restart_loads", n_load - base, 2);
      check_rows(base, 400, 2);
      chki("clr_one_done", n_done - d0, 1);

      // zero tiles: immediate done, no loads
      base = n_load; d0 = n_done;
      do_start(3, 0, 0);
      chkb("t0_done", done_o, 1'b1);
      idle(2);
      chki("t0_loads", n_load - base, 0);
      chki("t0_done_once", n_done - d0, 1);

      // rows=0 means a full W-row tile
      base = n_load;
      do_start(0, 0, 1);
      for (int i = 0; i < 12; i++) push_row(row(500 + i));
      wait_loads(base + 12);
      idle(2);
      chki("r0_loads", n_load - base, 12);
      ack(1'b1);
      check_rows(base, 500, 12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
